// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame parser/buffer behind uart_rx (SOF|LEN|PAYLOAD|CSUM).
// Optional counters: define UART_RX_FRAME_CTRL_STATS_EN to add frame_cnt_o/err_cnt_o.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SofByte      = 8'hA5,
    parameter int unsigned MaxLen       = 16,
    parameter int unsigned TimeoutTicks = 2560
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        tick_i,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        busy_o,
    output logic [3:0]  err_o
`ifdef UART_RX_FRAME_CTRL_STATS_EN
    ,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
`endif
);

    localparam int IW = $clog2(MaxLen + 1);
    localparam int AW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam int TW = $clog2(TimeoutTicks + 1);

    localparam logic [8:0]    MAXL  = 9'(MaxLen);
    localparam logic [TW-1:0] TLAST = TW'(TimeoutTicks - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    err_q, err_d;
    logic          wr_en;
    logic          rx_phase;
    logic          last_rd;

    logic [7:0]    mem_q [MaxLen];

    // Payload-receiving states are the only ones the inter-byte timer watches.
    assign rx_phase = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                   || (state_q == S_CSUM);

    assign last_rd = (rd_idx_q == len_q - IW'(1));

    // Next-state and datapath updates for the frame parser.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        csum_d   = csum_q;
        tcnt_d   = tcnt_q;
        err_d    = '0;
        wr_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid_i && rx_data_i == SofByte) begin
                    state_d = S_LEN;
                    tcnt_d  = '0;
                end
            end
            S_LEN: begin
                if (rx_valid_i) begin
                    tcnt_d = '0;
                    if (rx_data_i == 8'd0 || {1'b0, rx_data_i} > MAXL) begin
                        err_d[0] = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        len_d    = IW'(rx_data_i);
                        csum_d   = rx_data_i;
                        wr_idx_d = '0;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid_i) begin
                    tcnt_d   = '0;
                    wr_en    = 1'b1;
                    csum_d   = csum_q ^ rx_data_i;
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (wr_idx_q == len_q - IW'(1)) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid_i) begin
                    tcnt_d = '0;
                    if (rx_data_i == csum_q) begin
                        rd_idx_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        err_d[1] = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // A byte arriving while draining has nowhere to go.
                if (rx_valid_i) begin
                    err_d[3] = 1'b1;
                end
                if (m_ready_i) begin
                    if (last_rd) begin
                        rd_idx_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte on the terminal tick wins: its branch above already cleared the timer.
        if (rx_phase && !rx_valid_i && tick_i) begin
            if (tcnt_q == TLAST) begin
                err_d[2] = 1'b1;
                state_d  = S_IDLE;
                tcnt_d   = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // State, counters and registered error pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            csum_q   <= '0;
            tcnt_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            csum_q   <= csum_d;
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
        end
    end

    // Payload buffer; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx_q[AW-1:0]] <= rx_data_i;
        end
    end

    assign m_valid_o = (state_q == S_DRAIN);
    assign m_data_o  = m_valid_o ? mem_q[rd_idx_q[AW-1:0]] : 8'd0;
    assign m_last_o  = m_valid_o && last_rd;
    assign busy_o    = (state_q != S_IDLE);
    assign err_o     = err_q;

`ifdef UART_RX_FRAME_CTRL_STATS_EN
    logic frame_done;

    assign frame_done = m_valid_o && m_ready_i && m_last_o;

    // Saturating frame and error-cycle counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            if (frame_done && frame_cnt_o != 16'hFFFF) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
            if ((|err_q) && err_cnt_o != 16'hFFFF) begin
                err_cnt_o <= err_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed vectors for uart_rx_frame_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_rx_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        tick_i = 1'b0;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i = 1'b0;
    logic        busy_o;
    logic [3:0]  err_o;
`ifdef UART_RX_FRAME_CTRL_STATS_EN
    logic [15:0] frame_cnt_o;
    logic [15:0] err_cnt_o;
`endif

    int nvec = 0;
    int nerr = 0;

    uart_rx_frame_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .tick_i      (tick_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_last_o    (m_last_o),
        .m_ready_i   (m_ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
`ifdef UART_RX_FRAME_CTRL_STATS_EN
        ,
        .frame_cnt_o (frame_cnt_o),
        .err_cnt_o   (err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        step();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'd0;
    endtask

    task automatic send_frame1();
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h03);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_valid", m_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_last", m_last_o, 0);
        rst_i = 1'b0;
        step();

        // 1: good frame, ready held high
        m_ready_i = 1'b1;
        send_frame1();
        check("t1_v0", m_valid_o, 1);
        check("t1_d0", m_data_o, 8'h11);
        check("t1_l0", m_last_o, 0);
        check("t1_e0", err_o, 0);
        step();
        check("t1_d1", m_data_o, 8'h22);
        check("t1_l1", m_last_o, 0);
        step();
        check("t1_d2", m_data_o, 8'h33);
        check("t1_l2", m_last_o, 1);
        check("t1_e2", err_o, 0);
        step();
        check("t1_vend", m_valid_o, 0);
        check("t1_bend", busy_o, 0);

        // 2: checksum error (expected 32, sent 00)
        send(8'hA5);
        send(8'h02);
        send(8'h10);
        send(8'h20);
        send(8'h00);
        check("t2_err", err_o, 4'b0010);
        check("t2_valid", m_valid_o, 0);
        check("t2_busy", busy_o, 0);
        step();
        check("t2_pulse", err_o, 0);
        check("t2_valid2", m_valid_o, 0);

        // 3: length errors and idle junk
        send(8'hA5);
        send(8'h00);
        check("t3_len0", err_o, 4'b0001);
        check("t3_len0_busy", busy_o, 0);
        send(8'hA5);
        send(8'h11);
        check("t3_len17", err_o, 4'b0001);
        send(8'h00);
        check("t3_j00", {busy_o, m_valid_o, err_o}, 0);
        send(8'hFF);
        check("t3_jFF", {busy_o, m_valid_o, err_o}, 0);
        send(8'h5A);
        check("t3_j5A", {busy_o, m_valid_o, err_o}, 0);

        // Max length frame: 00..0F, csum = 10 ^ 00 ^ ... ^ 0F = 10
        send(8'hA5);
        send(8'h10);
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'h10);
        for (int i = 0; i < 16; i++) begin
            check("max_d", m_data_o, i);
            check("max_l", m_last_o, (i == 15) ? 1 : 0);
            step();
        end
        check("max_end", busy_o, 0);

        // Single-byte frame: 01 5A, csum 5B
        send(8'hA5);
        send(8'h01);
        send(8'h5A);
        send(8'h5B);
        check("one_d", m_data_o, 8'h5A);
        check("one_l", m_last_o, 1);
        step();
        check("one_end", m_valid_o, 0);

        // 4: timeout on the 2560th tick
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        tick_i = 1'b1;
        repeat (2559) step();
        check("t4_pre_err", err_o, 0);
        check("t4_pre_busy", busy_o, 1);
        step();
        tick_i = 1'b0;
        check("t4_err", err_o, 4'b0100);
        check("t4_busy", busy_o, 0);

        // 4b: byte on the terminal tick wins
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        tick_i = 1'b1;
        repeat (2559) step();
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h02;
        step();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tick_i     = 1'b0;
        check("t4b_err", err_o, 0);
        check("t4b_busy", busy_o, 1);
        send(8'h03);
        send(8'h04);
        send(8'h00);
        check("t4b_d0", m_data_o, 8'h01);
        check("t4b_v0", m_valid_o, 1);
        repeat (4) step();
        check("t4b_end", busy_o, 0);

        // 5: stalled drain with overrun bytes
        m_ready_i = 1'b0;
        send_frame1();
        check("t5_v", m_valid_o, 1);
        check("t5_d", m_data_o, 8'h11);
        repeat (3) step();
        send(8'h77);
        check("t5_ovr", err_o, 4'b1000);
        check("t5_hold", m_data_o, 8'h11);
        check("t5_hv", m_valid_o, 1);
        step();
        check("t5_pulse", err_o, 0);
        send(8'hA5);
        check("t5_sof", err_o, 4'b1000);
        repeat (2) step();
        check("t5_hold2", m_data_o, 8'h11);
        check("t5_l0", m_last_o, 0);
        m_ready_i = 1'b1;
        step();
        check("t5_d1", m_data_o, 8'h22);
        step();
        check("t5_d2", m_data_o, 8'h33);
        check("t5_l2", m_last_o, 1);
        step();
        check("t5_end", {busy_o, m_valid_o}, 0);
        send(8'h03);
        send(8'h11);
        check("t5_nosof", {busy_o, err_o}, 0);

        // 6: reset mid-payload
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        check("t6_busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("t6_rst", {busy_o, m_valid_o, m_last_o, err_o, m_data_o}, 0);
        step();
        rst_i = 1'b0;
        step();
        send_frame1();
        check("t6_d0", m_data_o, 8'h11);
        check("t6_e0", err_o, 0);
        step();
        check("t6_d1", m_data_o, 8'h22);
        step();
        check("t6_d2", m_data_o, 8'h33);
        check("t6_l2", m_last_o, 1);
        step();
        check("t6_end", busy_o, 0);
`ifdef UART_RX_FRAME_CTRL_STATS_EN
        check("t6_fcnt", frame_cnt_o, 1);
        check("t6_ecnt", err_cnt_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
